jpeg_pixel_writer: RTL and testbench
====================================

Name: jpeg_pixel_writer

Overview:
- Downstream consumer of the JPEG decoder's MCU-ordered pixel stream.
- Converts (MCU x/y, in-MCU address, RGB) beats into linear frame-buffer write transactions, clipped to image and buffer bounds.
- Handles 4:1:1 (16x16 MCU) and 4:4:4 (8x8 MCU) geometry and applies backpressure to the decoder.
- Signals end of frame once the last MCU has been written.

Parameters:
- FB_W, 640, frame-buffer width in pixels.
- FB_H, 480, frame-buffer height in pixels.
- FB_ADDR_WIDTH, 19, write-address width; must satisfy 2^FB_ADDR_WIDTH >= FB_W*FB_H.

Ports:
- clk  in  1  single clock, shared with decoder and frame-buffer write side.
- rst  in  1  synchronous, active-high reset.
- start  in  1  arm for one frame; ignored unless IDLE or DONE.
- cfg_en  in  1  decoder configuration valid.
- cfg_411  in  1  1 = 16x16 MCU, 0 = 8x8 MCU.
- cfg_width  in  16  image width in pixels.
- cfg_height  in  16  image height in pixels.
- cfg_mcu_w  in  13  MCUs per row.
- cfg_mcu_h  in  13  MCU rows.
- pix_we  in  1  pixel beat valid.
- pix_begin  in  1  first beat of an MCU.
- pix_end  in  1  last beat of an MCU.
- pix_r, pix_g, pix_b  in  8 each  colour.
- pix_adr  in  8  pixel index within the MCU, row-major.
- pix_x_mcu  in  13  MCU column.
- pix_y_mcu  in  13  MCU row.
- pix_next  out  1  ready; a beat is accepted when pix_we && pix_next.
- fb_wr_en  out  1  write strobe.
- fb_wr_ready  in  1  frame buffer can take a write this cycle.
- fb_wr_addr  out  FB_ADDR_WIDTH  y*FB_W + x.
- fb_wr_data  out  24  {r,g,b}.
- busy  out  1  state is WAIT_CFG, RUN or DRAIN.
- frame_done  out  1  one-cycle pulse on entry to DONE.
- done  out  1  level while in DONE.
- err  out  1  sticky protocol error.
- wr_count  out  20  pixels written this frame.
- clip_count  out  20  pixels accepted but dropped by clipping.

Behaviour:
- Reset: state IDLE; all outputs 0, including pix_next, fb_wr_en, counters and err; pipeline valids cleared. Reset mid-frame abandons the frame immediately; no further writes are issued.
- FSM states: IDLE, WAIT_CFG, RUN, DRAIN, DONE.
  - IDLE -> WAIT_CFG on start. Counters and err are cleared on this transition.
  - WAIT_CFG: on cfg_en, latch all cfg_* inputs, then -> RUN. pix_next is 0 in this state.
  - RUN -> DRAIN when a beat is accepted with pix_end=1, pix_x_mcu==mcu_w-1 and pix_y_mcu==mcu_h-1.
  - DRAIN -> DONE when both pipeline stages are empty; frame_done pulses for that one cycle.
  - DONE -> WAIT_CFG on start, clearing counters and err.
  - start in WAIT_CFG, RUN or DRAIN has no effect.
- Stage 1 (coordinates):
  - 4:1:1: x = x_mcu*16 + adr[3:0], y = y_mcu*16 + adr[7:4].
  - 4:4:4: x = x_mcu*8 + adr[2:0], y = y_mcu*8 + adr[5:3].
  - x and y are 16-bit with no overflow wrap; saturate at 0xFFFF, which is clipped.
- Stage 2 (clip and address):
  - keep = x < min(cfg_width, FB_W) && y < min(cfg_height, FB_H).
  - keep: issue fb_wr_en with fb_wr_addr = y*FB_W + x.
  - not keep: no write; clip_count increments.
- Latency: 2 cycles from acceptance to fb_wr_en when fb_wr_ready=1.
- Backpressure:
  - Stage 2 holds address/data with fb_wr_en asserted while fb_wr_ready=0.
  - The pipeline advances when stage 2 is empty or fb_wr_ready=1.
  - pix_next = (state==RUN) && advance, registered-free (combinational from state and fb_wr_ready).
  - Throughput is 1 pixel/cycle with no bubbles.
- Counters: wr_count increments on fb_wr_en && fb_wr_ready. Both counters saturate at all-ones.
- Errors (each sets err):
  - 4:4:4 beat with adr > 63: beat is accepted and dropped, not counted as clipped.
  - pix_x_mcu >= mcu_w or pix_y_mcu >= mcu_h: beat is dropped the same way.
- Simultaneous cases:
  - Last-MCU pix_end accepted while fb_wr_ready=0: enter DRAIN anyway; stage 2 drains before DONE.
  - cfg_en outside WAIT_CFG is ignored.

Decomposition:
- Shared package jpeg_pkg:
  - MCU_DIM_411=16, MCU_DIM_444=8.
  - Writer FSM state encoding.
  - RGB888 width constant 24.
- Sub-module jpeg_mcu_coord: combinational MCU/adr-to-x,y mapping plus adr range check. Reused later by the scaler.
- FSM, pipeline, clip and counters stay in jpeg_pixel_writer.

Test Plan:
- 4:1:1 at 32x16, 2 MCUs, fb_wr_ready=1 -> 512 writes; MCU1 adr 17 writes addr 1*640+17 = 657; frame_done pulses once, 2 cycles after the last beat; wr_count=512.
- 4:4:4 at 8x8, one MCU -> 64 writes; adr 63 writes addr 7*640+7 = 4487; clip_count=0.
- 4:1:1 with cfg_width=20, cfg_height=10, 2x1 MCUs -> wr_count=200, clip_count=312; no fb_wr_addr with x>=20 or y>=10.
- fb_wr_ready toggling 1,0,0,1 through a frame -> pix_next low whenever the pipeline stalls; fb_wr_addr/fb_wr_data stable while held; write sequence identical to the unstalled run.
- 4:4:4 beat with adr=100, then a pulse on start during RUN -> err=1, no write for that beat, state unchanged, frame still completes.
- rst asserted after 100 beats, then start + cfg_en -> all outputs 0 the cycle after reset; the new frame's first write is at MCU (0,0) and wr_count restarts from 0.

Source files
------------

// File: rtl/jpeg_pkg.sv
// Shared JPEG constants and types: MCU geometry, pixel width and the pixel-writer FSM encoding.
package jpeg_pkg;

    localparam int MCU_DIM_411 = 16;
    localparam int MCU_DIM_444 = 8;
    localparam int RGB_W       = 24;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_CFG,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } wr_state_t;

    // Coordinates that overflow 16 bits pin to 0xFFFF so they are always clipped.
    function automatic logic [15:0] sat16(input logic [16:0] v);
        return v[16] ? 16'hFFFF : v[15:0];
    endfunction

endpackage

// File: rtl/jpeg_mcu_coord.sv
// Combinational MCU/in-MCU-address to pixel x,y mapping with an address range check.
module jpeg_mcu_coord
    import jpeg_pkg::*;
(
    input  logic        i_is_411,
    input  logic [12:0] i_x_mcu,
    input  logic [12:0] i_y_mcu,
    input  logic [7:0]  i_adr,
    output logic [15:0] o_x,
    output logic [15:0] o_y,
    output logic        o_adr_ok
);

    logic [16:0] w_x_411;
    logic [16:0] w_y_411;
    logic [16:0] w_x_444;
    logic [16:0] w_y_444;

    assign w_x_411 = 17'(i_x_mcu) * 17'(MCU_DIM_411) + 17'(i_adr[3:0]);
    assign w_y_411 = 17'(i_y_mcu) * 17'(MCU_DIM_411) + 17'(i_adr[7:4]);
    assign w_x_444 = 17'(i_x_mcu) * 17'(MCU_DIM_444) + 17'(i_adr[2:0]);
    assign w_y_444 = 17'(i_y_mcu) * 17'(MCU_DIM_444) + 17'(i_adr[5:3]);

    assign o_x = sat16(i_is_411 ? w_x_411 : w_x_444);
    assign o_y = sat16(i_is_411 ? w_y_411 : w_y_444);

    // Every 8-bit address is inside a 16x16 MCU; an 8x8 MCU only has 64 pixels.
    assign o_adr_ok = i_is_411 || (i_adr < 8'(MCU_DIM_444 * MCU_DIM_444));

endmodule

// File: rtl/jpeg_pixel_writer.sv
// Turns the decoder's MCU-ordered pixel beats into clipped linear frame-buffer writes
// through a two-stage pipeline (coordinates, then clip/address) with backpressure.
module jpeg_pixel_writer
    import jpeg_pkg::*;
#(
    parameter int FB_W          = 640,
    parameter int FB_H          = 480,
    parameter int FB_ADDR_WIDTH = 19
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     cfg_en,
    input  logic                     cfg_411,
    input  logic [15:0]              cfg_width,
    input  logic [15:0]              cfg_height,
    input  logic [12:0]              cfg_mcu_w,
    input  logic [12:0]              cfg_mcu_h,
    input  logic                     pix_we,
    input  logic                     pix_begin,
    input  logic                     pix_end,
    input  logic [7:0]               pix_r,
    input  logic [7:0]               pix_g,
    input  logic [7:0]               pix_b,
    input  logic [7:0]               pix_adr,
    input  logic [12:0]              pix_x_mcu,
    input  logic [12:0]              pix_y_mcu,
    output logic                     pix_next,
    output logic                     fb_wr_en,
    input  logic                     fb_wr_ready,
    output logic [FB_ADDR_WIDTH-1:0] fb_wr_addr,
    output logic [RGB_W-1:0]         fb_wr_data,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     done,
    output logic                     err,
    output logic [19:0]              wr_count,
    output logic [19:0]              clip_count
);

    localparam logic [15:0] FB_W16 = 16'(FB_W);
    localparam logic [15:0] FB_H16 = 16'(FB_H);

    wr_state_t r_state;
    wr_state_t w_state_next;

    logic                     r_is_411;
    logic [12:0]              r_mcu_w;
    logic [12:0]              r_mcu_h;
    logic [15:0]              r_lim_x;
    logic [15:0]              r_lim_y;

    logic                     r_s1_valid;
    logic                     r_s1_drop;
    logic [15:0]              r_s1_x;
    logic [15:0]              r_s1_y;
    logic [RGB_W-1:0]         r_s1_rgb;

    logic                     r_s2_valid;
    logic [FB_ADDR_WIDTH-1:0] r_s2_addr;
    logic [RGB_W-1:0]         r_s2_data;

    logic                     r_err;
    logic                     r_frame_done;
    logic [19:0]              r_wr_count;
    logic [19:0]              r_clip_count;

    logic [15:0]              w_x;
    logic [15:0]              w_y;
    logic                     w_adr_ok;
    logic                     w_mcu_ok;
    logic                     w_beat_ok;
    logic                     w_last_mcu;
    logic                     w_advance;
    logic                     w_accept;
    logic                     w_keep;
    logic                     w_clear;
    logic [FB_ADDR_WIDTH-1:0] w_fb_addr;
    logic                     w_unused_begin;

    assign w_unused_begin = pix_begin;

    jpeg_mcu_coord u_coord (
        .i_is_411 (r_is_411),
        .i_x_mcu  (pix_x_mcu),
        .i_y_mcu  (pix_y_mcu),
        .i_adr    (pix_adr),
        .o_x      (w_x),
        .o_y      (w_y),
        .o_adr_ok (w_adr_ok)
    );

    assign w_mcu_ok   = (pix_x_mcu < r_mcu_w) && (pix_y_mcu < r_mcu_h);
    assign w_beat_ok  = w_adr_ok && w_mcu_ok;
    assign w_last_mcu = pix_end && (pix_x_mcu == r_mcu_w - 13'd1)
                                && (pix_y_mcu == r_mcu_h - 13'd1);

    // Both stages move together whenever stage 2 is free or is being drained this cycle.
    assign w_advance = !r_s2_valid || fb_wr_ready;
    assign w_accept  = pix_we && pix_next;
    assign w_keep    = (r_s1_x < r_lim_x) && (r_s1_y < r_lim_y);
    assign w_fb_addr = FB_ADDR_WIDTH'(32'(r_s1_y) * 32'(FB_W) + 32'(r_s1_x));
    assign w_clear   = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: if (start)                        w_state_next = ST_WAIT_CFG;
            ST_WAIT_CFG:      if (cfg_en)                       w_state_next = ST_RUN;
            ST_RUN:           if (w_accept && w_last_mcu)       w_state_next = ST_DRAIN;
            ST_DRAIN:         if (!r_s1_valid && !r_s2_valid)   w_state_next = ST_DONE;
            default:                                            w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        pix_next = (r_state == ST_RUN) && w_advance;
        busy     = (r_state == ST_WAIT_CFG) || (r_state == ST_RUN) || (r_state == ST_DRAIN);
        done     = (r_state == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_frame_done <= 1'b0;
            r_is_411     <= 1'b0;
            r_mcu_w      <= '0;
            r_mcu_h      <= '0;
            r_lim_x      <= '0;
            r_lim_y      <= '0;
            r_s1_valid   <= 1'b0;
            r_s1_drop    <= 1'b0;
            r_s1_x       <= '0;
            r_s1_y       <= '0;
            r_s1_rgb     <= '0;
            r_s2_valid   <= 1'b0;
            r_s2_addr    <= '0;
            r_s2_data    <= '0;
            r_err        <= 1'b0;
            r_wr_count   <= '0;
            r_clip_count <= '0;
        end else begin
            r_state      <= w_state_next;
            r_frame_done <= (r_state == ST_DRAIN) && (w_state_next == ST_DONE);

            if ((r_state == ST_WAIT_CFG) && cfg_en) begin
                r_is_411 <= cfg_411;
                r_mcu_w  <= cfg_mcu_w;
                r_mcu_h  <= cfg_mcu_h;
                r_lim_x  <= (cfg_width  < FB_W16) ? cfg_width  : FB_W16;
                r_lim_y  <= (cfg_height < FB_H16) ? cfg_height : FB_H16;
            end

            if (w_advance) begin
                r_s1_valid <= w_accept;
                if (w_accept) begin
                    r_s1_drop <= !w_beat_ok;
                    r_s1_x    <= w_x;
                    r_s1_y    <= w_y;
                    r_s1_rgb  <= {pix_r, pix_g, pix_b};
                end
                r_s2_valid <= r_s1_valid && !r_s1_drop && w_keep;
                if (r_s1_valid) begin
                    r_s2_addr <= w_fb_addr;
                    r_s2_data <= r_s1_rgb;
                end
            end

            if (w_clear) begin
                r_err        <= 1'b0;
                r_wr_count   <= '0;
                r_clip_count <= '0;
            end else begin
                if (w_accept && !w_beat_ok)
                    r_err <= 1'b1;
                if (r_s2_valid && fb_wr_ready && (r_wr_count != '1))
                    r_wr_count <= r_wr_count + 20'd1;
                // Protocol-error drops are not clipping, so they never reach this count.
                if (w_advance && r_s1_valid && !r_s1_drop && !w_keep && (r_clip_count != '1))
                    r_clip_count <= r_clip_count + 20'd1;
            end
        end
    end

    assign fb_wr_en   = r_s2_valid;
    assign fb_wr_addr = r_s2_addr;
    assign fb_wr_data = r_s2_data;
    assign frame_done = r_frame_done;
    assign err        = r_err;
    assign wr_count   = r_wr_count;
    assign clip_count = r_clip_count;

endmodule

// File: tb/tb_jpeg_pixel_writer.sv
// Directed bench for jpeg_pixel_writer: full frames in both geometries, clipping,
// write backpressure, protocol errors, and reset in the middle of a frame.
module tb_jpeg_pixel_writer;

    localparam int FB_W = 640;
    localparam int FB_H = 480;
    localparam int AW   = 19;

    logic          clk = 1'b0;
    logic          rst, start, cfg_en, cfg_411;
    logic [15:0]   cfg_width, cfg_height;
    logic [12:0]   cfg_mcu_w, cfg_mcu_h;
    logic          pix_we, pix_begin, pix_end;
    logic [7:0]    pix_r, pix_g, pix_b, pix_adr;
    logic [12:0]   pix_x_mcu, pix_y_mcu;
    logic          pix_next, fb_wr_en, fb_wr_ready;
    logic [AW-1:0] fb_wr_addr;
    logic [23:0]   fb_wr_data;
    logic          busy, frame_done, done, err;
    logic [19:0]   wr_count, clip_count;

    jpeg_pixel_writer #(.FB_W(FB_W), .FB_H(FB_H), .FB_ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_en(cfg_en), .cfg_411(cfg_411),
        .cfg_width(cfg_width), .cfg_height(cfg_height),
        .cfg_mcu_w(cfg_mcu_w), .cfg_mcu_h(cfg_mcu_h),
        .pix_we(pix_we), .pix_begin(pix_begin), .pix_end(pix_end),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b), .pix_adr(pix_adr),
        .pix_x_mcu(pix_x_mcu), .pix_y_mcu(pix_y_mcu), .pix_next(pix_next),
        .fb_wr_en(fb_wr_en), .fb_wr_ready(fb_wr_ready),
        .fb_wr_addr(fb_wr_addr), .fb_wr_data(fb_wr_data),
        .busy(busy), .frame_done(frame_done), .done(done), .err(err),
        .wr_count(wr_count), .clip_count(clip_count)
    );

    initial forever #5 clk = ~clk;

    int          n_err = 0;
    int          n_chk = 0;
    int          cyc = 0;
    int          fd_count = 0;
    int          fd_cyc = 0;
    int          last_wr_cyc = 0;
    int          stall_seen = 0;
    int          exp_clip = 0;
    bit          stall_en = 1'b0;
    logic [3:0]  stall_pat = 4'b1001;
    logic [42:0] wr_q[$];
    logic [42:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Write-side ready: free-running 1,0,0,1 pattern while stalling is enabled.
    initial begin
        int ph;
        ph = 0;
        fb_wr_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_en) begin
                fb_wr_ready = stall_pat[ph];
                ph = (ph + 1) % 4;
            end else begin
                fb_wr_ready = 1'b1;
            end
        end
    end

    // Write monitor: records completed writes and checks that held writes stay put.
    initial begin
        bit          held;
        logic [AW-1:0] h_addr;
        logic [23:0] h_data;
        held = 1'b0;
        forever begin
            @(negedge clk);
            if (held) begin
                chk("hold_en", fb_wr_en, 1'b1);
                chk("hold_addr", fb_wr_addr, h_addr);
                chk("hold_data", fb_wr_data, h_data);
            end
            if (frame_done) begin
                fd_count++;
                fd_cyc = cyc;
            end
            if (fb_wr_en && fb_wr_ready) begin
                wr_q.push_back({fb_wr_addr, fb_wr_data});
                last_wr_cyc = cyc;
            end
            if (fb_wr_en && !fb_wr_ready) begin
                stall_seen++;
                chk("stall_pix_next", pix_next, 1'b0);
                held   = 1'b1;
                h_addr = fb_wr_addr;
                h_data = fb_wr_data;
            end else begin
                held = 1'b0;
            end
        end
    end

    task automatic build_exp(input bit is411, input int w, input int h, input int mw, input int mh);
        int dim, lx, ly, x, y;
        logic [23:0] d;
        exp_q.delete();
        exp_clip = 0;
        dim = is411 ? 16 : 8;
        lx  = (w < FB_W) ? w : FB_W;
        ly  = (h < FB_H) ? h : FB_H;
        for (int my = 0; my < mh; my++)
            for (int mx = 0; mx < mw; mx++)
                for (int a = 0; a < dim * dim; a++) begin
                    x = mx * dim + a % dim;
                    y = my * dim + a / dim;
                    d = {8'(a), 8'(mx), 8'(my) ^ 8'h5A};
                    if (x < lx && y < ly) exp_q.push_back({19'(y * FB_W + x), d});
                    else                  exp_clip++;
                end
    endtask

    // Called at a falling edge; returns at the falling edge after the beat is taken.
    task automatic send_beat(input logic [12:0] xm, input logic [12:0] ym, input logic [7:0] adr,
                             input logic b, input logic e);
        int guard;
        pix_we = 1'b1; pix_begin = b; pix_end = e;
        pix_x_mcu = xm; pix_y_mcu = ym; pix_adr = adr;
        pix_r = adr; pix_g = xm[7:0]; pix_b = ym[7:0] ^ 8'h5A;
        guard = 0;
        #1;
        while (!pix_next && guard < 1000) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (guard >= 1000) chk("beat_timeout", 1'b0, 1'b1);
        @(negedge clk);
    endtask

    task automatic send_frame(input bit is411, input int mw, input int mh, input int limit);
        int dim, cnt;
        dim = is411 ? 16 : 8;
        cnt = 0;
        for (int my = 0; my < mh; my++)
            for (int mx = 0; mx < mw; mx++)
                for (int a = 0; a < dim * dim; a++) begin
                    if (limit >= 0 && cnt >= limit) begin
                        pix_we = 1'b0;
                        return;
                    end
                    send_beat(13'(mx), 13'(my), 8'(a), a == 0, a == dim * dim - 1);
                    cnt++;
                end
        pix_we = 1'b0;
    endtask

    task automatic start_frame(input bit is411, input int w, input int h, input int mw, input int mh);
        @(negedge clk);
        wr_q.delete();
        fd_count = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("wait_cfg_busy", busy, 1'b1);
        chk("wait_cfg_next", pix_next, 1'b0);
        cfg_411 = is411; cfg_width = 16'(w); cfg_height = 16'(h);
        cfg_mcu_w = 13'(mw); cfg_mcu_h = 13'(mh);
        cfg_en = 1'b1;
        @(negedge clk);
        cfg_en = 1'b0;
    endtask

    task automatic wait_done();
        int g;
        g = 0;
        while (!done && g < 5000) begin
            @(negedge clk);
            g++;
        end
        chk("done_reached", done, 1'b1);
        #1;
    endtask

    task automatic cmp_seq(input string tag);
        int mism, n;
        mism = 0;
        chk({tag, "_len"}, wr_q.size(), exp_q.size());
        n = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            if (wr_q[i] !== exp_q[i]) mism++;
        chk({tag, "_seq"}, mism, 0);
    endtask

    initial begin
        int found, viol, px, py;
        logic [42:0] ent;
        rst = 1'b1; start = 1'b0; cfg_en = 1'b0; cfg_411 = 1'b0;
        cfg_width = '0; cfg_height = '0; cfg_mcu_w = '0; cfg_mcu_h = '0;
        pix_we = 1'b0; pix_begin = 1'b0; pix_end = 1'b0;
        pix_r = '0; pix_g = '0; pix_b = '0; pix_adr = '0; pix_x_mcu = '0; pix_y_mcu = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_pix_next", pix_next, 1'b0);
        chk("rst_wr_en", fb_wr_en, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_counts", {wr_count, clip_count}, 40'd0);

        // 4:1:1, two 16x16 MCUs fully inside a 32x16 image
        build_exp(1'b1, 32, 16, 2, 1);
        start_frame(1'b1, 32, 16, 2, 1);
        send_frame(1'b1, 2, 1, -1);
        wait_done();
        cmp_seq("t411");
        found = 0;
        foreach (wr_q[i]) if (wr_q[i] === {19'd657, 8'd17, 8'd1, 8'h5A}) found++;
        chk("t411_addr657", found, 1);
        chk("t411_wr_count", wr_count, 20'd512);
        chk("t411_clip", clip_count, 20'd0);
        chk("t411_fd_count", fd_count, 1);
        chk("t411_fd_lat", fd_cyc - last_wr_cyc, 2);
        chk("t411_busy", busy, 1'b0);
        $display("t411 frame: writes=%0d wr_count=%0d", wr_q.size(), wr_count);

        // 4:4:4, single 8x8 MCU
        build_exp(1'b0, 8, 8, 1, 1);
        start_frame(1'b0, 8, 8, 1, 1);
        send_frame(1'b0, 1, 1, -1);
        wait_done();
        cmp_seq("t444");
        ent = (wr_q.size() > 0) ? wr_q[wr_q.size() - 1] : '0;
        chk("t444_last_addr", ent[42:24], 19'd4487);
        chk("t444_clip", clip_count, 20'd0);
        $display("t444 frame: writes=%0d wr_count=%0d", wr_q.size(), wr_count);

        // 4:1:1 clipped to 20x10
        build_exp(1'b1, 20, 10, 2, 1);
        start_frame(1'b1, 20, 10, 2, 1);
        send_frame(1'b1, 2, 1, -1);
        wait_done();
        cmp_seq("tclip");
        chk("tclip_wr", wr_count, 20'd200);
        chk("tclip_clip", clip_count, 20'd312);
        chk("tclip_model", exp_clip, 312);
        viol = 0;
        foreach (wr_q[i]) begin
            px = int'(wr_q[i][42:24]) % FB_W;
            py = int'(wr_q[i][42:24]) / FB_W;
            if (px >= 20 || py >= 10) viol++;
        end
        chk("tclip_bounds", viol, 0);
        $display("tclip frame: wr_count=%0d clip_count=%0d", wr_count, clip_count);

        // Same 32x16 frame with write-side stalls
        stall_seen = 0;
        stall_en = 1'b1;
        build_exp(1'b1, 32, 16, 2, 1);
        start_frame(1'b1, 32, 16, 2, 1);
        send_frame(1'b1, 2, 1, -1);
        wait_done();
        stall_en = 1'b0;
        cmp_seq("tstall");
        chk("tstall_wr", wr_count, 20'd512);
        chk("tstall_seen", stall_seen > 0, 1'b1);
        $display("tstall frame: writes=%0d stalls=%0d", wr_q.size(), stall_seen);

        // Protocol errors and start during RUN
        build_exp(1'b0, 8, 8, 1, 1);
        start_frame(1'b0, 8, 8, 1, 1);
        send_beat(13'd0, 13'd0, 8'd100, 1'b0, 1'b0);
        send_beat(13'd3, 13'd0, 8'd5, 1'b0, 1'b0);
        pix_we = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("terr_err", err, 1'b1);
        chk("terr_busy", busy, 1'b1);
        chk("terr_next", pix_next, 1'b1);
        @(negedge clk);
        chk("terr_no_write", wr_q.size(), 0);
        send_frame(1'b0, 1, 1, -1);
        wait_done();
        cmp_seq("terr");
        chk("terr_wr", wr_count, 20'd64);
        chk("terr_clip", clip_count, 20'd0);
        chk("terr_sticky", err, 1'b1);
        $display("terr frame: writes=%0d err=%0d", wr_q.size(), err);

        // Reset after 100 beats, then a fresh frame
        build_exp(1'b1, 32, 16, 2, 1);
        start_frame(1'b1, 32, 16, 2, 1);
        send_frame(1'b1, 2, 1, 100);
        chk("trst_pre_wr", wr_count != 20'd0, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("trst_wr_en", fb_wr_en, 1'b0);
        chk("trst_next", pix_next, 1'b0);
        chk("trst_busy", busy, 1'b0);
        chk("trst_flags", {done, frame_done, err}, 3'b000);
        chk("trst_counts", {wr_count, clip_count}, 40'd0);
        chk("trst_addr", fb_wr_addr, 19'd0);
        start_frame(1'b1, 32, 16, 2, 1);
        send_frame(1'b1, 2, 1, -1);
        wait_done();
        ent = (wr_q.size() > 0) ? wr_q[0] : '1;
        chk("trst_first", ent, {19'd0, 8'd0, 8'd0, 8'h5A});
        chk("trst_wr", wr_count, 20'd512);
        cmp_seq("trst");
        $display("trst frame: writes=%0d wr_count=%0d", wr_q.size(), wr_count);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
